// File: rtl/aes_pkg.sv
// aes_pkg: shared AES state types and constants for the SubBytes engine
package aes_pkg;
  localparam int NUM_BYTES = 16;
  localparam int BYTE_W = 8;
  typedef logic [NUM_BYTES*BYTE_W-1:0] aes_state_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/aes_sbox_lut.sv
// aes_sbox_lut: combinational forward/inverse AES S-box lookup
module aes_sbox_lut
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] i_byte,
  input  logic              i_inv,
  output logic [BYTE_W-1:0] o_byte
);
  localparam logic [0:255][BYTE_W-1:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [0:255][BYTE_W-1:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };
  assign o_byte = i_inv ? INV[i_byte] : FWD[i_byte];
endmodule

// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: iterative AES SubBytes, LANES in-place S-box lookups per cycle
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       inverse,
  input  logic       clear,
  input  aes_state_t state_in,
  output logic       ready,
  output logic       done,
  output aes_state_t state_out
);
  localparam int GROUPS = NUM_BYTES / LANES;
  localparam int CNT_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(GROUPS - 1);
  state_e r_state;
  logic [CNT_W-1:0] r_cnt;
  aes_state_t r_work;
  logic r_inv;
  logic r_done;
  logic r_ready;
  aes_state_t w_next;
  logic [LANES-1:0][BYTE_W-1:0] w_sub;
  int w_base;
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("LANES must be 1, 2, 4, 8 or 16");
  end
  // byte k lives at state[127-8k -: 8]; the current group starts at byte c*LANES
  assign w_base = int'(r_cnt) * LANES;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox_lut u_sbox (
      .i_byte(r_work[BYTE_W*(NUM_BYTES-1-(w_base+l)) +: BYTE_W]),
      .i_inv (r_inv),
      .o_byte(w_sub[l])
    );
  end
  always_comb begin
    w_next = r_work;
    for (int l = 0; l < LANES; l++) w_next[BYTE_W*(NUM_BYTES-1-(w_base+l)) +: BYTE_W] = w_sub[l];
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
      r_inv   <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else if (clear) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
      r_inv   <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= RUN;
            r_work  <= state_in;
            r_inv   <= inverse;
            r_cnt   <= '0;
            r_ready <= 1'b0;
          end else begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
        RUN: begin
          r_work <= w_next;
          if (r_cnt == LAST) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end
  assign ready     = r_ready;
  assign done      = r_done;
  assign state_out = r_work;
endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb_sub_bytes_engine: table-driven scoreboard bench for LANES = 4, 1 and 16 instances
module tb_sub_bytes_engine;
  import aes_pkg::*;
  typedef struct {int d; aes_state_t data; logic inv; aes_state_t exp;} vec_t;
  typedef struct {int d; aes_state_t exp;} sb_t;
  localparam int LAT [3] = '{5, 17, 2};
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic inverse = 1'b0;
  logic clear = 1'b0;
  aes_state_t state_in = '0;
  logic start_v [3];
  logic ready_v [3];
  logic done_v [3];
  aes_state_t out_v [3];
  int n_chk = 0;
  int n_pass = 0;
  int n_done [3] = '{0, 0, 0};
  sb_t sb [$];
  sb_t sb_e;
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];
  vec_t vt [$];

  always #5 clk = ~clk;

  sub_bytes_engine #(.LANES(4)) u_l4 (
    .clk(clk), .n_rst(n_rst), .start(start_v[0]), .inverse(inverse), .clear(clear),
    .state_in(state_in), .ready(ready_v[0]), .done(done_v[0]), .state_out(out_v[0]));
  sub_bytes_engine #(.LANES(1)) u_l1 (
    .clk(clk), .n_rst(n_rst), .start(start_v[1]), .inverse(inverse), .clear(clear),
    .state_in(state_in), .ready(ready_v[1]), .done(done_v[1]), .state_out(out_v[1]));
  sub_bytes_engine #(.LANES(16)) u_l16 (
    .clk(clk), .n_rst(n_rst), .start(start_v[2]), .inverse(inverse), .clear(clear),
    .state_in(state_in), .ready(ready_v[2]), .done(done_v[2]), .state_out(out_v[2]));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // GF(2^8) arithmetic gives an S-box independent of the lookup tables
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x = 8'h00;
    for (int i = 1; i < 256; i++) if (gmul(a, 8'(i)) == 8'h01) x = 8'(i);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
  endfunction

  function automatic aes_state_t model(input aes_state_t s, input logic inv);
    aes_state_t r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv ? inv_t[s[127-8*k -: 8]] : fwd_t[s[127-8*k -: 8]];
    return r;
  endfunction

  always @(negedge clk) begin
    for (int j = 0; j < 3; j++) if (done_v[j]) begin
      n_done[j]++;
      if (sb.size() == 0 || sb[0].d != j) chk($sformatf("unexpected_done_%0d", j), 1, 0);
      else begin
        sb_e = sb.pop_front();
        chk($sformatf("result_%0d", j), out_v[j], sb_e.exp);
      end
    end
  end

  task automatic start_op(input int d, input aes_state_t data, input logic inv, input aes_state_t exp);
    state_in = data;
    inverse = inv;
    start_v[d] = 1'b1;
    sb.push_back('{d, exp});
    @(negedge clk);
    start_v[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int cyc = 1;
    int bad = 0;
    while (!done_v[d] && cyc < 40) begin
      if (ready_v[d]) bad++;
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("latency_%0d", d), cyc, LAT[d]);
    chk($sformatf("ready_low_in_run_%0d", d), bad, 0);
    chk($sformatf("ready_at_done_%0d", d), ready_v[d], 1);
  endtask

  task automatic run(input vec_t v);
    @(negedge clk);
    start_op(v.d, v.data, v.inv, v.exp);
    wait_done(v.d);
    @(negedge clk);
    chk("hold_in_idle", out_v[v.d], v.exp);
    chk("ready_in_idle", ready_v[v.d], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    aes_state_t a, b, p;
    int nd;
    for (int j = 0; j < 3; j++) start_v[j] = 1'b0;
    for (int i = 0; i < 256; i++) fwd_t[i] = sbox(8'(i));
    for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);
    #1 n_rst = 1'b0;
    #2;
    for (int j = 0; j < 3; j++) begin
      chk("reset_out", out_v[j], 0);
      chk("reset_ready", ready_v[j], 1);
      chk("reset_done", done_v[j], 0);
    end
    @(negedge clk);
    n_rst = 1'b1;
    vt.push_back('{0, 128'h00112233445566778899aabbccddeeff, 1'b0, 128'h638293c31bfc33f5c4eeacea4bc12816});
    vt.push_back('{0, 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, 128'h00112233445566778899aabbccddeeff});
    vt.push_back('{1, {16{8'h53}}, 1'b0, {16{8'hed}}});
    vt.push_back('{2, {16{8'h53}}, 1'b0, {16{8'hed}}});
    vt.push_back('{1, {16{8'hed}}, 1'b1, {16{8'h53}}});
    vt.push_back('{2, {16{8'hed}}, 1'b1, {16{8'h53}}});
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 16; k++) p[127-8*k -: 8] = 8'(16*i + k);
      vt.push_back('{0, p, 1'b0, model(p, 1'b0)});
      vt.push_back('{0, model(p, 1'b0), 1'b1, p});
    end
    for (int i = 0; i < 6; i++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      vt.push_back('{i % 3, p, 1'(i / 3), model(p, 1'(i / 3))});
    end
    foreach (vt[i]) run(vt[i]);
    // start with new data and mode mid-run must be ignored
    a = 128'h3243f6a8885a308d313198a2e0370734;
    b = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    @(negedge clk);
    nd = n_done[0];
    start_op(0, a, 1'b0, model(a, 1'b0));
    state_in = b;
    inverse = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    inverse = 1'b0;
    repeat (12) @(negedge clk);
    chk("run_start_one_done", n_done[0] - nd, 1);
    chk("run_start_result", out_v[0], model(a, 1'b0));
    // back-to-back: second start lands in the DONE cycle
    @(negedge clk);
    start_op(0, a, 1'b0, model(a, 1'b0));
    wait_done(0);
    start_op(0, b, 1'b1, model(b, 1'b1));
    wait_done(0);
    @(negedge clk);
    chk("b2b_hold", out_v[0], model(b, 1'b1));
    // async reset during RUN cycle 2
    @(negedge clk);
    start_op(0, a, 1'b0, model(a, 1'b0));
    nd = n_done[0];
    n_rst = 1'b0;
    #1;
    chk("rst_mid_out", out_v[0], 0);
    chk("rst_mid_ready", ready_v[0], 1);
    chk("rst_mid_done", done_v[0], 0);
    void'(sb.pop_back());
    @(negedge clk);
    n_rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_mid_no_done", n_done[0] - nd, 0);
    chk("rst_mid_out_held", out_v[0], 0);
    run('{0, b, 1'b0, model(b, 1'b0)});
    // clear together with start on the final RUN cycle suppresses done
    @(negedge clk);
    start_op(0, a, 1'b0, model(a, 1'b0));
    nd = n_done[0];
    repeat (3) @(negedge clk);
    clear = 1'b1;
    start_v[0] = 1'b1;
    state_in = b;
    @(negedge clk);
    clear = 1'b0;
    start_v[0] = 1'b0;
    chk("clr_out", out_v[0], 0);
    chk("clr_ready", ready_v[0], 1);
    chk("clr_done", done_v[0], 0);
    void'(sb.pop_back());
    repeat (8) @(negedge clk);
    chk("clr_no_done", n_done[0] - nd, 0);
    chk("clr_out_held", out_v[0], 0);
    run('{0, a, 1'b1, model(a, 1'b1)});
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
